// File: rtl/dose_scheduler.sv
// Dose scheduler: per-slot minute countdowns feeding a round-robin alarm FSM
// with acknowledge, snooze and missed-dose timeout.
module dose_slot #(
    parameter int CNT_W = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             min_tick_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             clr_i,
    output logic             active_o,
    output logic             pending_o,
    output logic             dup_o
);
    logic [CNT_W-1:0] interval_q, interval_d, count_q, count_d;
    logic             pending_q, pending_d, expire;

    always_comb begin
        interval_d = interval_q;
        count_d    = count_q;
        pending_d  = pending_q;
        expire     = 1'b0;
        if (load_i) begin
            interval_d = load_val_i;
            count_d    = load_val_i;
            pending_d  = 1'b0;
        end else begin
            // interval 0 freezes the slot, so the reload can never underflow
            if (min_tick_i && interval_q != '0) begin
                if (count_q == CNT_W'(1)) begin
                    expire  = 1'b1;
                    count_d = interval_q;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            pending_d = (pending_q & ~clr_i) | expire;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            interval_q <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
        end else begin
            interval_q <= interval_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
        end
    end

    assign active_o  = (interval_d != '0);
    assign pending_o = pending_q;
    // a fresh expiry landing on an unserved dose means the older one is lost
    assign dup_o     = expire & pending_q & ~clr_i;
endmodule

module dose_scheduler #(
    parameter  int NUM_SLOTS  = 4,
    parameter  int CNT_W      = 11,
    parameter  int SNOOZE_MIN = 5,
    parameter  int MISS_LIMIT = 30,
    localparam int SW         = $clog2(NUM_SLOTS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             min_tick,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_slot,
    input  logic [CNT_W-1:0] cfg_interval,
    input  logic             ack,
    input  logic             snooze,
    output logic             tmr_enable,
    output logic             alarm,
    output logic [SW-1:0]    alarm_slot,
    output logic             missed_pulse
);
    localparam int MMAX = (MISS_LIMIT > SNOOZE_MIN) ? MISS_LIMIT : SNOOZE_MIN;
    localparam int MW   = $clog2(MMAX + 1);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ALARM  = 2'd1;
    localparam logic [1:0] S_SNOOZE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [SW-1:0]        slot_q, slot_d, rr_q, rr_d, mslot_q, mslot_d, pick, dslot, slot_nxt;
    logic [MW-1:0]        mcnt_q, mcnt_d;
    logic                 missed_q, missed_d, tmr_en_q, found, fsm_miss, cfg_hit;
    logic [NUM_SLOTS-1:0] load_vec, clr_vec, active_vec, pend_vec, dup_vec, pend_vis;
    int                   arb_k;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        dose_slot #(.CNT_W(CNT_W)) u_slot (
            .clock      (clock),
            .reset      (reset),
            .min_tick_i (min_tick),
            .load_i     (load_vec[g]),
            .load_val_i (cfg_interval),
            .clr_i      (clr_vec[g]),
            .active_o   (active_vec[g]),
            .pending_o  (pend_vec[g]),
            .dup_o      (dup_vec[g])
        );
    end

    always_comb begin
        load_vec = '0;
        if (cfg_we) load_vec[cfg_slot] = 1'b1;
    end

    // a slot being rewritten this cycle is not offered to the arbiter
    assign pend_vis = pend_vec & ~load_vec;
    assign slot_nxt = (slot_q == SW'(NUM_SLOTS - 1)) ? '0 : slot_q + SW'(1);
    assign cfg_hit  = cfg_we && (cfg_slot == slot_q) && (state_q != S_IDLE);

    always_comb begin
        found = 1'b0;
        pick  = '0;
        arb_k = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            arb_k = int'(rr_q) + i;
            if (arb_k >= NUM_SLOTS) arb_k = arb_k - NUM_SLOTS;
            if (!found && pend_vis[SW'(arb_k)]) begin
                found = 1'b1;
                pick  = SW'(arb_k);
            end
        end
        dslot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (dup_vec[i]) dslot = SW'(i);
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        rr_d     = rr_q;
        mcnt_d   = mcnt_q;
        clr_vec  = '0;
        fsm_miss = 1'b0;
        case (state_q)
            S_IDLE: if (found) begin
                slot_d  = pick;
                mcnt_d  = '0;
                state_d = S_ALARM;
            end
            S_ALARM: begin
                if (cfg_hit) begin
                    state_d = S_IDLE;
                end else if (ack) begin
                    clr_vec[slot_q] = 1'b1;
                    rr_d            = slot_nxt;
                    state_d         = S_IDLE;
                end else if (snooze) begin
                    mcnt_d  = '0;
                    state_d = S_SNOOZE;
                end else if (min_tick) begin
                    if (mcnt_q == MW'(MISS_LIMIT - 1)) begin
                        fsm_miss        = 1'b1;
                        clr_vec[slot_q] = 1'b1;
                        rr_d            = slot_nxt;
                        state_d         = S_IDLE;
                    end else begin
                        mcnt_d = mcnt_q + MW'(1);
                    end
                end
            end
            S_SNOOZE: begin
                if (cfg_hit) begin
                    state_d = S_IDLE;
                end else if (min_tick) begin
                    if (mcnt_q == MW'(SNOOZE_MIN - 1)) begin
                        mcnt_d  = '0;
                        state_d = S_ALARM;
                    end else begin
                        mcnt_d = mcnt_q + MW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // the FSM's own timeout pulse wins over a countdown overrun
        missed_d = fsm_miss | (|dup_vec);
        mslot_d  = fsm_miss ? slot_q : dslot;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            slot_q   <= '0;
            rr_q     <= '0;
            mcnt_q   <= '0;
            missed_q <= 1'b0;
            mslot_q  <= '0;
            tmr_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            rr_q     <= rr_d;
            mcnt_q   <= mcnt_d;
            missed_q <= missed_d;
            mslot_q  <= mslot_d;
            tmr_en_q <= |active_vec;
        end
    end

    assign alarm        = (state_q == S_ALARM);
    assign alarm_slot   = missed_q ? mslot_q : slot_q;
    assign missed_pulse = missed_q;
    assign tmr_enable   = tmr_en_q;
endmodule

// File: tb/tb_dose_scheduler.sv
// Directed bench for dose_scheduler: expected alarm/missed events are queued
// as stimulus is applied and checked when the DUT raises them.
module tb_dose_scheduler;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        min_tick = 1'b0, cfg_we = 1'b0, ack = 1'b0, snooze = 1'b0;
    logic [1:0]  cfg_slot = '0;
    logic [10:0] cfg_interval = '0;
    logic        tmr_enable, alarm, missed_pulse;
    logic [1:0]  alarm_slot;

    int total = 0, bad = 0;
    logic alarm_prev = 1'b0, rose = 1'b0;

    typedef struct { string tag; int kind; int slot; } exp_t;  // kind 0 alarm, 1 missed
    exp_t exp_q[$];

    dose_scheduler dut (
        .clock(clock), .reset(reset), .min_tick(min_tick), .cfg_we(cfg_we),
        .cfg_slot(cfg_slot), .cfg_interval(cfg_interval), .ack(ack), .snooze(snooze),
        .tmr_enable(tmr_enable), .alarm(alarm), .alarm_slot(alarm_slot),
        .missed_pulse(missed_pulse)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic mt, input logic we, input logic [1:0] sl,
                        input logic [10:0] iv, input logic a, input logic s);
        @(negedge clock);
        alarm_prev = alarm;
        min_tick = mt; cfg_we = we; cfg_slot = sl; cfg_interval = iv; ack = a; snooze = s;
        @(posedge clock);
        #1;
        min_tick = 0; cfg_we = 0; ack = 0; snooze = 0;
        rose = alarm && !alarm_prev;
    endtask

    task automatic idle();        step(0, 0, 0, 0, 0, 0); endtask
    task automatic tick();        step(1, 0, 0, 0, 0, 0); endtask
    task automatic cfg(input logic [1:0] sl, input logic [10:0] iv); step(0, 1, sl, iv, 0, 0); endtask
    task automatic do_ack();      step(0, 0, 0, 0, 1, 0); endtask

    task automatic expect_ev(input string tag, input int kind, input int slot);
        exp_t e;
        e.tag = tag; e.kind = kind; e.slot = slot;
        exp_q.push_back(e);
    endtask

    task automatic wait_ev(input int bound);
        exp_t e;
        bit got = 0;
        for (int n = 0; n < bound && !got; n++) begin
            idle();
            if (rose || missed_pulse) got = 1;
        end
        if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "_seen"}, int'(got), 1);
            if (got) begin
                check({e.tag, "_kind"}, missed_pulse ? 1 : 0, e.kind);
                check({e.tag, "_slot"}, int'(alarm_slot), e.slot);
            end
        end
    endtask

    initial begin
        // reset state
        idle(); idle();
        check("rst_alarm", int'(alarm), 0);
        check("rst_slot", int'(alarm_slot), 0);
        check("rst_missed", int'(missed_pulse), 0);
        check("rst_tmr", int'(tmr_enable), 0);
        reset = 1'b1;
        idle();

        // 1: slot0 interval 3, alarm two edges after the third tick
        cfg(0, 3); idle();
        check("t1_tmr_on", int'(tmr_enable), 1);
        tick(); tick();
        check("t1_quiet", int'(alarm), 0);
        tick();
        check("t1_edge1", int'(alarm), 0);
        idle();
        check("t1_alarm", int'(alarm), 1);
        check("t1_slot", int'(alarm_slot), 0);
        do_ack();
        check("t1_ack", int'(alarm), 0);
        cfg(0, 0); idle();
        check("t1_tmr_off", int'(tmr_enable), 0);

        // 2: two slots expire together, served in round-robin order
        cfg(1, 2); cfg(2, 2);
        tick(); tick();
        expect_ev("t2_first", 0, 1);
        wait_ev(4);
        do_ack();
        expect_ev("t2_second", 0, 2);
        wait_ev(4);
        do_ack();
        cfg(1, 0); cfg(2, 0); idle();
        check("t2_idle", int'(alarm), 0);

        // 3: snooze defers the alarm by five ticks
        cfg(0, 20);
        for (int i = 0; i < 20; i++) tick();
        expect_ev("t3_alarm", 0, 0);
        wait_ev(4);
        step(0, 0, 0, 0, 0, 1);
        check("t3_snoozed", int'(alarm), 0);
        for (int i = 0; i < 4; i++) tick();
        check("t3_tick4", int'(alarm), 0);
        tick();
        check("t3_tick5", int'(alarm), 1);
        check("t3_slot", int'(alarm_slot), 0);
        do_ack(); idle(); idle();
        check("t3_cleared", int'(alarm), 0);
        cfg(0, 0);

        // 3b: a second expiry on an unserved dose reports it missed
        cfg(0, 2);
        tick(); tick();
        expect_ev("t3b_alarm", 0, 0);
        wait_ev(4);
        tick();
        check("t3b_nomiss", int'(missed_pulse), 0);
        tick();
        check("t3b_miss", int'(missed_pulse), 1);
        check("t3b_mslot", int'(alarm_slot), 0);
        check("t3b_still", int'(alarm), 1);
        do_ack(); cfg(0, 0); idle();

        // 4: unanswered alarm times out after 30 ticks
        cfg(0, 40);
        for (int i = 0; i < 40; i++) tick();
        expect_ev("t4_alarm", 0, 0);
        wait_ev(4);
        for (int i = 0; i < 29; i++) tick();
        check("t4_pre_miss", int'(missed_pulse), 0);
        check("t4_pre_alarm", int'(alarm), 1);
        tick();
        check("t4_miss", int'(missed_pulse), 1);
        check("t4_mslot", int'(alarm_slot), 0);
        check("t4_alarm_off", int'(alarm), 0);
        idle();
        check("t4_one_cycle", int'(missed_pulse), 0);
        check("t4_no_rearm", int'(alarm), 0);
        cfg(0, 0);

        // 5: disabling the alarmed slot drops the alarm silently
        cfg(3, 2);
        tick(); tick();
        expect_ev("t5_alarm", 0, 3);
        wait_ev(4);
        cfg(3, 0);
        check("t5_drop", int'(alarm), 0);
        check("t5_nomiss", int'(missed_pulse), 0);
        idle();
        check("t5_tmr", int'(tmr_enable), 0);
        check("t5_nomiss2", int'(missed_pulse), 0);

        // 6: reset during an alarm
        cfg(1, 2);
        tick(); tick();
        expect_ev("t6_alarm", 0, 1);
        wait_ev(4);
        reset = 1'b0;
        idle();
        check("t6_alarm", int'(alarm), 0);
        check("t6_slot", int'(alarm_slot), 0);
        check("t6_missed", int'(missed_pulse), 0);
        check("t6_tmr", int'(tmr_enable), 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        idle(); idle();
        check("t6_quiet", int'(alarm), 0);

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
